// File: rtl/mem_pkg.sv
// Shared SRAM request-controller types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

  // Controller FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_RSP,
    ST_RMW_RD,
    ST_RMW_WAIT,
    ST_WR
  } ctrl_state_e;

  // Byte-enable pattern that needs no read-modify-write
  localparam logic [3:0] BE_FULL = 4'hF;

  // Words below this address are write-protected (byte addresses below 1000)
  localparam int PROT_WORDS_DEFAULT = 250;

endpackage

// File: rtl/sram_byte_merge.sv
// Byte-lane merge: each byte comes from new_word where be is set, else old_word.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake.
module sram_byte_merge
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_word,
  input  logic [DATA_WIDTH-1:0]   new_word,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   merged
);

  // Start from the old word and overwrite only the enabled byte lanes
  always_comb begin
    merged = old_word;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/sram_req_ctrl.sv
// Converts byte-addressed load/store requests into single-port SRAM accesses (RMW for partial stores).
// Latency: load data 2 cycles after accept; full store writes 1 cycle, partial store 3 cycles after accept.
// Backpressure: one request in flight; req_ready only in IDLE, load data held in RSP until rsp_ready.
module sram_req_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int PROT_WORDS = PROT_WORDS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  wr_err,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_data,
  output logic                  sram_we,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam logic [ADDR_WIDTH-1:0] PROT_LIMIT = ADDR_WIDTH'(PROT_WORDS);

  ctrl_state_e           state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [3:0]            be_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] merged;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] req_word;
  logic                  req_prot;

  // The byte offset is irrelevant for word accesses; the latched we is kept for debug visibility only
  logic unused_ok;
  assign unused_ok = ^{req_addr[1:0], we_q};

  assign req_word  = req_addr[ADDR_WIDTH+1:2];
  assign req_prot  = (req_word < PROT_LIMIT);

  // SRAM port is driven only from the latched request registers
  assign sram_addr = addr_q;
  assign sram_data = data_q;

  sram_byte_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_merge (
    .old_word (sram_q),
    .new_word (data_q),
    .be       (be_q),
    .merged   (merged)
  );

  // State register; reset aborts any in-flight access and drops sram_we immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and state-derived handshake/strobe outputs
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    sram_we   = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (!req_we) begin
            state_nxt = ST_RD;
          end else if (req_prot || (req_be == 4'h0)) begin
            // Protected or empty store is dropped; stay ready for the next request
            state_nxt = ST_IDLE;
          end else if (req_be == BE_FULL) begin
            state_nxt = ST_WR;
          end else begin
            state_nxt = ST_RMW_RD;
          end
        end
      end
      ST_RD:       state_nxt = ST_RD_WAIT;
      ST_RD_WAIT:  state_nxt = ST_RSP;
      ST_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RMW_RD:   state_nxt = ST_RMW_WAIT;
      ST_RMW_WAIT: state_nxt = ST_WR;
      ST_WR: begin
        sram_we   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Latch the request on accept; fold old SRAM bytes into the write word once the RMW read returns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
      be_q   <= '0;
      we_q   <= 1'b0;
    end else if (accept) begin
      addr_q <= req_word;
      data_q <= req_wdata;
      be_q   <= req_be;
      we_q   <= req_we;
    end else if (state == ST_RMW_WAIT) begin
      data_q <= merged;
    end
  end

  // Capture load data as the SRAM read completes; held stable through RSP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
    end else if (state == ST_RD_WAIT) begin
      rsp_rdata <= sram_q;
    end
  end

  // Sticky flag for dropped protected stores; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err <= 1'b0;
    end else if (accept && req_we && req_prot) begin
      wr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Self-checking bench for sram_req_ctrl with a read-first SRAM model and a load-data scoreboard.
// Latency: n/a.
// Backpressure: exercised by holding rsp_ready low.
module tb_sram_req_ctrl;

  localparam int DW = 32;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW+1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0]    req_be = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          wr_err;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data;
  logic          sram_we;
  logic [DW-1:0] sram_q;

  sram_req_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .wr_err    (wr_err),
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .sram_we   (sram_we),
    .sram_q    (sram_q)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Read-first synchronous SRAM, one-cycle read latency
  logic [DW-1:0] mem [logic [AW-1:0]];
  always @(posedge clk) begin
    sram_q <= mem.exists(sram_addr) ? mem[sram_addr] : '0;
    if (sram_we) mem[sram_addr] = sram_data;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference memory holding the architecturally expected contents
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : '0;
  endfunction

  logic [DW-1:0] exp_q [$];

  // Scoreboard: compare load data on each response handshake
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
      else chk("rsp_data", rsp_rdata, exp_q.pop_front());
    end
  end

  // Record every SRAM write strobe
  int            we_cnt = 0;
  int            we_cyc = 0;
  logic [AW-1:0] we_addr = '0;
  logic [DW-1:0] we_data = '0;
  always @(negedge clk) begin
    if (sram_we) begin
      we_cnt  = we_cnt + 1;
      we_cyc  = cyc;
      we_addr = sram_addr;
      we_data = sram_data;
    end
  end

  int acc_cyc = 0;

  task automatic accept(input logic we, input logic [AW+1:0] addr,
                        input logic [DW-1:0] wd, input logic [3:0] be);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
  endtask

  task automatic store(input logic [AW+1:0] addr, input logic [DW-1:0] wd, input logic [3:0] be);
    logic [AW-1:0] w;
    logic [DW-1:0] v;
    w = addr[AW+1:2];
    if (w >= AW'(250) && be != 4'h0) begin
      v = ref_rd(w);
      for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = wd[8*i +: 8];
      ref_mem[w] = v;
    end
    accept(1'b1, addr, wd, be);
  endtask

  task automatic load(input logic [AW+1:0] addr);
    exp_q.push_back(ref_rd(addr[AW+1:2]));
    accept(1'b0, addr, '0, 4'h0);
  endtask

  task automatic wait_rsp_valid(output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) chk("rsp_valid_timeout", 32'd0, 32'd1);
    lat = cyc - acc_cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base;
    int n;

    // Reset held with random inputs
    repeat (4) begin
      @(negedge clk);
      req_valid = 1'($urandom);
      req_we    = 1'($urandom);
      req_addr  = 20'($urandom);
      req_wdata = $urandom;
      req_be    = 4'($urandom);
      rsp_ready = 1'($urandom);
    end
    @(negedge clk);
    chk("rst_sram_we", 32'(sram_we), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_sram_data", sram_data, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    req_valid = 1'b0;
    req_we    = 1'b0;
    rsp_ready = 1'b1;
    rst_n     = 1'b1;

    // Full store: one write cycle during the accept cycle
    base = we_cnt;
    store(20'h01000, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk("full_busy", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("full_ready_again", 32'(req_ready), 32'd1);
    idle(2);
    chk("full_we_count", 32'(we_cnt - base), 32'd1);
    chk("full_we_cycle", 32'(we_cyc - acc_cyc), 32'd0);
    chk("full_we_addr", 32'(we_addr), 32'h400);
    chk("full_we_data", we_data, 32'hDEADBEEF);

    // Load back with 2-cycle latency
    load(20'h01000);
    wait_rsp_valid(lat);
    chk("load_latency", 32'(lat), 32'd2);
    idle(2);

    // Partial store via read-modify-write
    base = we_cnt;
    store(20'h01000, 32'h00001234, 4'b0011);
    idle(5);
    chk("part_we_count", 32'(we_cnt - base), 32'd1);
    chk("part_we_cycle", 32'(we_cyc - acc_cyc), 32'd2);
    chk("part_we_data", we_data, 32'hDEAD1234);
    load(20'h01000);
    wait_rsp_valid(lat);
    chk("part_load_latency", 32'(lat), 32'd2);
    idle(2);

    // Empty byte-enable store does nothing
    base = we_cnt;
    store(20'h01000, 32'hFFFFFFFF, 4'h0);
    @(negedge clk);
    chk("be0_ready", 32'(req_ready), 32'd1);
    idle(3);
    chk("be0_we_count", 32'(we_cnt - base), 32'd0);

    // Response backpressure
    rsp_ready = 1'b0;
    load(20'h01000);
    wait_rsp_valid(lat);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hDEAD1234);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    load(20'h01000);
    wait_rsp_valid(lat);
    chk("bp_next_latency", 32'(lat), 32'd2);
    idle(2);

    // Protected region
    base = we_cnt;
    store(20'h00004, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    chk("prot_ready_next", 32'(req_ready), 32'd1);
    chk("prot_wr_err", 32'(wr_err), 32'd1);
    idle(3);
    chk("prot_we_count", 32'(we_cnt - base), 32'd0);
    base = we_cnt;
    store(20'h003E4, 32'h55667788, 4'hF);
    idle(3);
    chk("prot249_we_count", 32'(we_cnt - base), 32'd0);
    base = we_cnt;
    store(20'h003E8, 32'h11223344, 4'hF);
    idle(3);
    chk("prot250_we_count", 32'(we_cnt - base), 32'd1);
    chk("prot250_we_addr", 32'(we_addr), 32'd250);
    chk("prot_wr_err_sticky", 32'(wr_err), 32'd1);
    load(20'h003E8);
    load(20'h00004);
    load(20'h003E4);

    // Mixed stores and loads with random data and byte enables
    for (int i = 0; i < 6; i++) begin
      store(20'h02000 + 20'(i * 4), $urandom, 4'($urandom));
      store(20'h02000 + 20'(i * 4), $urandom, 4'($urandom));
      load(20'h02000 + 20'(i * 4));
    end
    idle(6);

    // Reset during RMW_WAIT discards the store
    base = we_cnt;
    accept(1'b1, 20'h01000, 32'hAAAAAAAA, 4'b1100);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rmw_rst_we", 32'(sram_we), 32'd0);
    chk("rmw_rst_ready", 32'(req_ready), 32'd1);
    chk("rmw_rst_wr_err", 32'(wr_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    chk("rmw_rst_we_count", 32'(we_cnt - base), 32'd0);
    load(20'h01000);
    wait_rsp_valid(lat);

    // Drain the scoreboard
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
